conv_window_scheduler: RTL and testbench
========================================

# conv_window_scheduler

Sequencing controller for one pipelined 2-D convolution engine. On a start pulse it walks every output position of a SIZE×SIZE input in raster order and issues one window coordinate per accepted handshake. It bounds the number of windows in flight, pairs each in-order engine result with its coordinate, and writes the result into the output feature map. It replaces the fixed quadrant/three-state sequencing with a credit-based, back-pressure-aware scheduler.

## Interface
Parameters:
- SIZE, 7: input matrix edge length.
- SIZEKER, 3: kernel edge length.
- WIDTH_BIT, 8: data width (signed).
- MAX_INFLIGHT, 4: maximum outstanding windows; power of two, ≥2.

Ports (all widths derive from `OUT_SIZE = SIZE-SIZEKER+1` and `IDXW = max(1, $clog2(OUT_SIZE))`):
- clock, in, 1: clock, rising edge.
- nreset, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin one frame; sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at frame completion.
- win_valid, out, 1: window coordinate valid.
- win_ready, in, 1: engine accepts window.
- win_row, out, IDXW: top-left row of the window.
- win_col, out, IDXW: top-left column of the window.
- res_valid, in, 1: engine result valid. Results return in issue order.
- res_data, in, WIDTH_BIT signed: engine result.
- out_we, out, 1: output write strobe.
- out_row, out, IDXW: output row address.
- out_col, out, IDXW: output column address.
- out_data, out, WIDTH_BIT signed: output value.
- err, out, 1: sticky; set by a result arriving with no window in flight.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when start=1. Issue counters clear to (0,0).
- ISSUE:
  - win_valid = (inflight < MAX_INFLIGHT).
  - Handshake: win_valid & win_ready. It pushes (row,col) into the coordinate FIFO and advances col; col wraps OUT_SIZE-1 → 0 with row+1.
  - The handshake on (OUT_SIZE-1, OUT_SIZE-1) moves to DRAIN.
- DRAIN: win_valid=0. DRAIN → DONE when inflight==0 and no retire is pending.
- DONE: done=1 for one cycle, then IDLE.
- Retire:
  - res_valid with a non-empty FIFO pops the head coordinate.
  - Next cycle drives out_we=1, out_row/out_col from the popped coordinate, and out_data from the processed res_data.
- inflight bookkeeping:
  - Issue and retire in the same cycle leave inflight unchanged.
  - inflight counts 0..MAX_INFLIGHT.
- res_valid with an empty FIFO: the result is dropped, err is set, and no write occurs.
- start while busy is ignored.
- win_row/win_col hold stable while win_valid=1 and win_ready=0.
- res_valid is accepted in any state, including IDLE; in IDLE it sets err.

## Timing
- Reset values (asynchronous): state IDLE; busy, done, win_valid, out_we, err all 0; all indices, out_data and inflight 0; FIFO empty.
- Reset mid-frame aborts immediately. No done pulse is produced, and the next frame starts from (0,0).
- start sampled at cycle t → busy=1 and win_valid=1 with (0,0) at t+1.
- Peak throughput is one issue and one retire per cycle.
- Latency from res_valid to out_we is 1 cycle.
- If the final result has res_valid at cycle t, out_we=1 at t+1, state DONE and done=1 at t+2, and busy=0 at t+3.
- Minimum frame length: OUT_SIZE² issue cycles plus engine latency plus 3.

## Configuration
- CONV_SCHED_RELU_EN defined: out_data = (res_data ≥ 0) ? res_data : 0.
- Undefined: out_data = res_data unmodified.
- Timing is identical in both builds.

## Structure
- Package conv_sched_pkg:
  - state enum sched_state_t {IDLE, ISSUE, DRAIN, DONE}.
  - Functions computing OUT_SIZE and IDXW from parameters.
- Sub-module coord_fifo:
  - Synchronous FIFO of {row,col}, depth MAX_INFLIGHT.
  - Ports: push, pop, full, empty, count.
  - Same reset scheme as this block.

## Test plan
- Single frame, SIZE=7, SIZEKER=3, win_ready=1, engine latency 2 → 25 issues (0,0)…(4,4) in raster order, 25 writes at matching addresses, one done pulse, err=0.
- Back-pressure: win_ready toggles 1/0 and an engine with latency 10 → inflight never exceeds 4, win_valid drops at 4 outstanding, coordinates are held while stalled, 25 writes still occur.
- ReLU: results −5, 0, 7 at the first three positions → with CONV_SCHED_RELU_EN, out_data 0, 0, 7; without it, out_data −5, 0, 7.
- Spurious result: res_valid pulse in IDLE → err=1, out_we stays 0, next frame runs normally with err still 1.
- Reset at issue 12 → all outputs 0 during and after reset; a new start yields (0,0) first and a full 25-write frame.
- start re-pulsed while busy and simultaneous issue+retire every cycle → second start ignored, inflight is constant in the steady state, exactly one done pulse.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// ============================================================================
// Module      : conv_sched_pkg
// Description : Shared state encoding and geometry helpers for the
//               convolution window scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  function automatic int out_size_f(input int size, input int sizeker);
    return size - sizeker + 1;
  endfunction

  // A 1x1 output map still needs a 1-bit index.
  function automatic int idxw_f(input int out_size);
    return (out_size > 1) ? $clog2(out_size) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_scheduler_fifo.sv
// ============================================================================
// Module      : coord_fifo
// Description : Synchronous FIFO holding the {row,col} of windows in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coord_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 6,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/conv_window_scheduler.sv
// ============================================================================
// Module      : conv_window_scheduler
// Description : Credit-based window issue / in-order result retire controller
//               for a pipelined 2-D convolution engine.
//               Optional ReLU on written results: CONV_SCHED_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int SIZE         = 7,
  parameter  int SIZEKER      = 3,
  parameter  int WIDTH_BIT    = 8,
  parameter  int MAX_INFLIGHT = 4,
  localparam int OUT_SIZE     = out_size_f(SIZE, SIZEKER),
  localparam int IDXW         = idxw_f(OUT_SIZE),
  localparam int CNTW         = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [IDXW-1:0]             win_row,
  output logic [IDXW-1:0]             win_col,
  input  logic                        res_valid,
  input  logic signed [WIDTH_BIT-1:0] res_data,
  output logic                        out_we,
  output logic [IDXW-1:0]             out_row,
  output logic [IDXW-1:0]             out_col,
  output logic signed [WIDTH_BIT-1:0] out_data,
  output logic                        err
);

  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(OUT_SIZE - 1);

  sched_state_t                state_q, state_d;
  logic [IDXW-1:0]             row_q, row_d, col_q, col_d;
  logic                        out_we_q, err_q;
  logic [IDXW-1:0]             out_row_q, out_col_q;
  logic signed [WIDTH_BIT-1:0] out_data_q, res_proc;

  logic                        fifo_full, fifo_empty;
  logic [CNTW-1:0]             fifo_count;
  logic [2*IDXW-1:0]           fifo_head;
  logic                        w_issue, w_pop, w_last;

  // The FIFO occupancy is the in-flight window count.
  assign win_valid = (state_q == ISSUE) & ~fifo_full;
  assign w_issue   = win_valid & win_ready;
  assign w_pop     = res_valid & ~fifo_empty;
  assign w_last    = (row_q == MAX_IDX) && (col_q == MAX_IDX);

  coord_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .DW    (2*IDXW)
  ) u_coord_fifo (
    .clock  (clock),
    .nreset (nreset),
    .push   (w_issue),
    .pop    (w_pop),
    .wdata  ({row_q, col_q}),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef CONV_SCHED_RELU_EN
  assign res_proc = res_data[WIDTH_BIT-1] ? '0 : res_data;
`else
  assign res_proc = res_data;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ISSUE: begin
        if (w_issue) begin
          if (w_last) begin
            state_d = DRAIN;
          end else if (col_q == MAX_IDX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((fifo_count == '0) && !w_pop) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      out_we_q   <= 1'b0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      out_we_q <= w_pop;
      if (w_pop) begin
        out_row_q  <= fifo_head[2*IDXW-1:IDXW];
        out_col_q  <= fifo_head[IDXW-1:0];
        out_data_q <= res_proc;
      end
      // A result with nothing in flight is dropped and flagged.
      err_q <= err_q | (res_valid & fifo_empty);
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign win_row  = row_q;
  assign win_col  = col_q;
  assign out_we   = out_we_q;
  assign out_row  = out_row_q;
  assign out_col  = out_col_q;
  assign out_data = out_data_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
// ============================================================================
// Module      : tb_conv_window_scheduler
// Description : Scoreboard bench for conv_window_scheduler with an in-order
//               engine model of configurable latency and back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_scheduler;

  localparam int N_WIN = 25;
  localparam int OUTSZ = 5;
  localparam int MAXI  = 4;

  logic              clock = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic              win_ready = 1'b0;
  logic              res_valid = 1'b0;
  logic signed [7:0] res_data = '0;
  logic              busy, done, win_valid, out_we, err;
  logic [2:0]        win_row, win_col, out_row, out_col;
  logic signed [7:0] out_data;

  conv_window_scheduler #(
    .SIZE(7), .SIZEKER(3), .WIDTH_BIT(8), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock(clock), .nreset(nreset), .start(start), .busy(busy), .done(done),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_col(win_col), .res_valid(res_valid), .res_data(res_data),
    .out_we(out_we), .out_row(out_row), .out_col(out_col),
    .out_data(out_data), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { int due; int data; } eng_t;
  typedef struct { int row; int col; int data; } exp_t;
  eng_t eng_q[$];
  exp_t exp_q[$];
  eng_t eh;
  exp_t ex;

  int checks = 0, errors = 0;
  int cyc = 0, lat = 2, ready_mode = 0, spur_req = 0, exp_err = 0;
  int issued = 0, writes = 0, dones = 0, outstanding = 0;
  int last_we_cyc = 0, done_cyc = 0, er = 0, ec = 0, v = 0;
  int hold_row = 0, hold_col = 0;
  bit stall_prev = 0, busy_prev = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int val_of(input int idx);
    case (idx)
      0:       return -5;
      1:       return 0;
      2:       return 7;
      default: return idx * 9 - 100;
    endcase
  endfunction

  function automatic int exp_out(input int val);
`ifdef CONV_SCHED_RELU_EN
    return (val < 0) ? 0 : val;
`else
    return val;
`endif
  endfunction

  // Engine model plus output scoreboard; all DUT sampling on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (!nreset) begin
      eng_q.delete(); exp_q.delete();
      outstanding = 0; issued = 0; er = 0; ec = 0; exp_err = 0;
      stall_prev = 0; busy_prev = 0;
      win_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    end else begin
      if (busy && !busy_prev) begin
        issued = 0; writes = 0; dones = 0; er = 0; ec = 0;
      end
      if (out_we) begin
        writes++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          ex = exp_q.pop_front();
          chk("out_row", int'(out_row), ex.row);
          chk("out_col", int'(out_col), ex.col);
          chk("out_data", int'(out_data), ex.data);
        end
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (stall_prev && win_valid) begin
        chk("hold_row", int'(win_row), hold_row);
        chk("hold_col", int'(win_col), hold_col);
      end
      if (busy && issued < N_WIN)
        chk("win_valid", int'(win_valid), int'(outstanding < MAXI));

      win_ready = (ready_mode != 0) ? cyc[0] : 1'b1;
      if (spur_req != 0) begin
        res_valid = 1'b1; res_data = 8'sd33; spur_req = 0; exp_err = 1;
      end else if (eng_q.size() > 0 && eng_q[0].due <= cyc) begin
        eh = eng_q.pop_front();
        res_valid = 1'b1; res_data = 8'(eh.data); outstanding--;
      end else begin
        res_valid = 1'b0;
      end

      if (win_valid && win_ready) begin
        chk("win_row", int'(win_row), er);
        chk("win_col", int'(win_col), ec);
        v = val_of(issued);
        eng_q.push_back('{cyc + lat, v});
        exp_q.push_back('{er, ec, exp_out(v)});
        outstanding++; issued++; ec++;
        if (ec == OUTSZ) begin ec = 0; er++; end
      end
      stall_prev = win_valid && !win_ready;
      hold_row   = int'(win_row);
      hold_col   = int'(win_col);
      busy_prev  = busy;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wvalid"}, int'(win_valid), 0);
    chk({tag, "_we"}, int'(out_we), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_idx"}, int'({win_row, win_col, out_row, out_col}), 0);
    chk({tag, "_odata"}, int'(out_data), 0);
  endtask

  task automatic run_frame(input bit repulse);
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_wvalid", int'(win_valid), 1);
    chk("start_coord", int'({win_row, win_col}), 0);
    if (repulse) begin
      repeat (6) step();
      start = 1'b1; step(); start = 1'b0;
    end
    for (int i = 0; i < 1500; i++) begin
      if (dones > 0) break;
      step();
    end
    chk("done_seen", dones, 1);
    step();
    chk("busy_after_done", int'(busy), 0);
    chk("done_count", dones, 1);
    chk("writes", writes, N_WIN);
    chk("issued", issued, N_WIN);
    chk("done_latency", done_cyc - last_we_cyc, 1);
    chk("err", int'(err), exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);
    repeat (3) step();
    chk("idle_stays", int'(busy), 0);
  endtask

  initial begin
    repeat (3) step();
    chk_zero("reset");
    nreset = 1'b1;
    step();

    lat = 2;  ready_mode = 0; run_frame(1'b0);
    lat = 10; ready_mode = 1; run_frame(1'b0);

    chk("err_pre_spur", int'(err), 0);
    spur_req = 1;
    repeat (3) step();
    chk("err_spur", int'(err), 1);
    chk("we_spur", int'(out_we), 0);
    lat = 2; ready_mode = 0; run_frame(1'b0);

    lat = 3; ready_mode = 1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (issued >= 12) break;
      step();
    end
    chk("reached_issue12", int'(issued >= 12), 1);
    nreset = 1'b0;
    step();
    chk_zero("in_reset");
    nreset = 1'b1;
    step();
    chk_zero("post_reset");
    lat = 3; ready_mode = 0; run_frame(1'b0);

    lat = 1; ready_mode = 0; run_frame(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
